// File: rtl/one2five_tx.sv
// Packet repeater: buffers one packet, then transmits it COPIES times with the copy number
// written over byte WHEREISID and GAP idle cycles after each copy.
module one2five_tx #(
   parameter int unsigned WHEREISID = 0,
   parameter int unsigned COPIES    = 5,
   parameter int unsigned MAXLEN    = 64,
   parameter int unsigned GAP       = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_in,
   input  logic [7:0] data_in,
   output logic       ready,
   output logic       tx_en,
   output logic [7:0] txdata,
   output logic [3:0] copy_id,
   output logic       done,
   output logic       overflow
);

   localparam int unsigned AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam int unsigned LW = $clog2(MAXLEN + 1);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

   logic [7:0]    mem [MAXLEN];
   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [3:0]    copy_q, copy_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          rd_vld_q, rd_vld_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          tx_en_q;
   logic [7:0]    txdata_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      copy_d    = copy_q;
      gap_d     = gap_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;
      wr_en     = 1'b0;
      wr_addr   = len_q[AW-1:0];
      rd_vld_d  = 1'b0;
      rd_data_d = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (en_in) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               len_d   = LW'(1);
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (en_in) begin
               if (len_q == LW'(MAXLEN)) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  len_d = len_q + LW'(1);
               end
            end else begin
               idx_d   = '0;
               copy_d  = 4'd1;
               state_d = StSend;
            end
         end
         StSend: begin
            // Buffer read is staged twice before the pins, giving the two-cycle start latency
            rd_vld_d  = 1'b1;
            rd_data_d = ({{(32-LW){1'b0}}, idx_q} == WHEREISID) ? {4'b0000, copy_q}
                                                                : mem[idx_q[AW-1:0]];
            if (en_in) ovf_d = 1'b1;
            if (idx_q == len_q - LW'(1)) begin
               gap_d   = '0;
               state_d = StGap;
            end else begin
               idx_d = idx_q + LW'(1);
            end
         end
         StGap: begin
            if (en_in) ovf_d = 1'b1;
            if (gap_q == GW'(GAP - 1)) begin
               if (copy_q == 4'(COPIES)) begin
                  done_d  = 1'b1;
                  copy_d  = 4'd0;
                  len_d   = '0;
                  idx_d   = '0;
                  state_d = StIdle;
               end else begin
                  copy_d  = copy_q + 4'd1;
                  idx_d   = '0;
                  state_d = StSend;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         idx_q     <= '0;
         copy_q    <= 4'd0;
         gap_q     <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
         txdata_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         copy_q    <= copy_d;
         gap_q     <= gap_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
         tx_en_q   <= rd_vld_q;
         txdata_q  <= rd_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_en) mem[wr_addr] <= data_in;
   end

   assign ready    = (state_q == StIdle);
   assign tx_en    = tx_en_q;
   assign txdata   = txdata_q;
   assign copy_id  = copy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule

// File: doc/one2five_tx.md
ONE2FIVE_TX -- requirements
Module: one2five_tx

Interface
REQ-001 SHALL have parameter WHEREISID, default 0: byte offset of the copy-id field in each transmitted packet.
REQ-002 SHALL have parameter COPIES, default 5: number of transmitted copies per packet (1..15).
REQ-003 SHALL have parameter MAXLEN, default 64: packet buffer depth in bytes (power of 2, 2..256).
REQ-004 SHALL have parameter GAP, default 12: idle cycles between copies (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port en_in  input  1  input byte valid, high for the whole packet.
REQ-008 SHALL have port data_in  input  8  input packet byte.
REQ-009 SHALL have port ready  output  1  high when en_in will be accepted (IDLE).
REQ-010 SHALL have port tx_en  output  1  transmit byte valid, registered.
REQ-011 SHALL have port txdata  output  8  transmit byte, registered.
REQ-012 SHALL have port copy_id  output  4  id (1..COPIES) of the copy in flight, 0 otherwise.
REQ-013 SHALL have port done  output  1  one-cycle pulse after last copy's gap.
REQ-014 SHALL have port overflow  output  1  sticky error flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, SEND, GAP.
REQ-016 IDLE: en_in=1 -> store data_in at address 0, len=1, go LOAD; ready=1 only in IDLE.
REQ-017 LOAD: each cycle en_in=1 stores data_in at address len, len+1; en_in=0 -> go SEND with copy index 1, byte index 0.
REQ-018 LOAD with len=MAXLEN and en_in=1: byte discarded, overflow set, packet truncated to MAXLEN.
REQ-019 SEND: one byte per cycle, tx_en=1, txdata=buffer[byte index], except byte index WHEREISID drives {4'b0, copy index}.
REQ-020 If len <= WHEREISID, no id substitution; packet sent unmodified.
REQ-021 Latency: with en_in sampled low at edge E, tx_en first high after edge E+2; tx_en stays high for exactly len consecutive cycles per copy.
REQ-022 After byte len-1, SHALL enter GAP for exactly GAP cycles with tx_en=0, txdata=0.
REQ-023 GAP end with copy index < COPIES: increment index, byte index 0, go SEND; with copy index = COPIES: done=1 for one cycle, go IDLE.
REQ-024 copy_id SHALL equal copy index during SEND and GAP, 0 in IDLE/LOAD.
REQ-025 en_in=1 outside IDLE/LOAD SHALL be ignored and set overflow; buffer contents unchanged while sending.
REQ-026 en_in dropping after a 1-byte packet SHALL still produce COPIES one-byte copies.
REQ-027 Back-to-back: en_in high in the cycle done pulses SHALL be accepted (IDLE entered same edge).
REQ-028 overflow SHALL clear only on reset.
REQ-029 Counters SHALL be sized to hold MAXLEN (len) and COPIES without wrap.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE, len=0, indices=0, tx_en=0, txdata=0, copy_id=0, done=0, overflow=0, ready=1 on the following cycle.
REQ-031 Reset mid-LOAD or mid-SEND SHALL abort the packet with no further tx_en; buffer contents need not be cleared.
REQ-032 Reset SHALL override all other inputs in the same cycle.

Verification
REQ-033 8-byte packet 0x10..0x17, defaults -> 5 copies, byte0 = 0x01..0x05, bytes1..7 = 0x11..0x17, 12 idle cycles between copies, one done pulse.
REQ-034 WHEREISID=3, 2-byte packet 0xAA,0xBB -> 5 copies of AA BB unmodified, copy_id 1..5.
REQ-035 MAXLEN=8, 10-byte packet -> overflow=1, each copy 8 bytes, id at byte 0.
REQ-036 en_in pulsed during copy 3 -> overflow=1, all 5 copies byte-identical to the unpulsed case.
REQ-037 rst=0 during copy 2 byte 4 -> tx_en=0 next cycle, ready=1, no done; new packet afterwards sent correctly.
REQ-038 Check latency: en_in low sampled at edge E -> tx_en high after E+2, exactly len cycles per copy.
